// File: rtl/booth_pp_gen_24x24_pkg.sv
// Shared widths and Booth digit codes for the 24x24 mantissa multiplier.
// Each code is packed as {one, two, neg}.
package booth_pp_gen_24x24_pkg;

    localparam int WIDTH  = 24;
    localparam int PP_W   = 26;
    localparam int NUM_PP = (WIDTH + 2) / 2;

    typedef struct packed {
        logic one;
        logic two;
        logic neg;
    } booth_code_t;

    localparam booth_code_t BOOTH_ZERO = 3'b000;
    localparam booth_code_t BOOTH_P1   = 3'b100;
    localparam booth_code_t BOOTH_P2   = 3'b010;
    localparam booth_code_t BOOTH_M1   = 3'b101;
    localparam booth_code_t BOOTH_M2   = 3'b011;

    // 111 maps to plain zero (not -0) so a negative zero never reaches the datapath.
    function automatic booth_code_t booth_encode(input logic [2:0] grp);
        booth_code_t code;
        case (grp)
            3'b001, 3'b010: code = BOOTH_P1;
            3'b011:         code = BOOTH_P2;
            3'b100:         code = BOOTH_M2;
            3'b101, 3'b110: code = BOOTH_M1;
            default:        code = BOOTH_ZERO;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/booth_pp_gen_24x24_booth_sel.sv
// One Booth group: encodes the live multiplier triplet, and forms the 26-bit
// partial product from the registered code and multiplicand.
module booth_sel
    import booth_pp_gen_24x24_pkg::*;
(
    input  logic [2:0]       grp,
    output logic [2:0]       code,
    input  logic [2:0]       code_r,
    input  logic [WIDTH-1:0] a,
    output logic [PP_W-1:0]  pp
);

    localparam logic [PP_W-1:0] PP_ONE = 1;

    booth_code_t     code_s;
    logic [PP_W-1:0] mag;

    assign code   = booth_encode(grp);
    assign code_s = booth_code_t'(code_r);

    // Full two's-complement negate here; the tree has no correction-bit input.
    always_comb begin
        mag = '0;
        if (code_s.one) begin
            mag = {2'b00, a};
        end else if (code_s.two) begin
            mag = {1'b0, a, 1'b0};
        end
        pp = code_s.neg ? (~mag + PP_ONE) : mag;
    end

endmodule

// File: rtl/booth_pp_gen_24x24.sv
// Radix-4 Booth partial-product generator: stage 1 registers A and group codes,
// stage 2 registers the 13 formed partial products. Valid/ready on both sides.
module booth_pp_gen_24x24
    import booth_pp_gen_24x24_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  multiplicand,
    input  logic [WIDTH-1:0]  multiplier,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PP_W-1:0]   partial_product1,
    output logic [PP_W-1:0]   partial_product2,
    output logic [PP_W-1:0]   partial_product3,
    output logic [PP_W-1:0]   partial_product4,
    output logic [PP_W-1:0]   partial_product5,
    output logic [PP_W-1:0]   partial_product6,
    output logic [PP_W-1:0]   partial_product7,
    output logic [PP_W-1:0]   partial_product8,
    output logic [PP_W-1:0]   partial_product9,
    output logic [PP_W-1:0]   partial_product10,
    output logic [PP_W-1:0]   partial_product11,
    output logic [PP_W-1:0]   partial_product12,
    output logic [PP_W-1:0]   partial_product13
);

    logic                               s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]                   a_q, a_d;
    logic [NUM_PP-1:0][2:0]             code_q, code_d, code_grp;
    logic                               out_valid_q, out_valid_d;
    logic [NUM_PP-1:0][PP_W-1:0]        pp_q, pp_d, pp_nxt;
    logic [2*NUM_PP:0]                  b_ext;
    logic                               s2_adv, s1_load;

    // Bit j of b_ext is b[j-1]: b[-1]=0 at the bottom, zero-extension on top.
    assign b_ext = {2'b00, multiplier, 1'b0};

    for (genvar k = 0; k < NUM_PP; k++) begin : g_sel
        booth_sel u_sel (
            .grp    (b_ext[2*k+2 -: 3]),
            .code   (code_grp[k]),
            .code_r (code_q[k]),
            .a      (a_q),
            .pp     (pp_nxt[k])
        );
    end

    assign s2_adv   = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_adv;
    assign s1_load  = in_valid && in_ready;

    always_comb begin
        s1_valid_d  = s1_load || (s1_valid_q && !s2_adv);
        a_d         = s1_load ? multiplicand : a_q;
        code_d      = s1_load ? code_grp : code_q;
        out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
        pp_d        = (s2_adv && s1_valid_q) ? pp_nxt : pp_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            a_q         <= '0;
            code_q      <= '0;
            out_valid_q <= 1'b0;
            pp_q        <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            a_q         <= a_d;
            code_q      <= code_d;
            out_valid_q <= out_valid_d;
            pp_q        <= pp_d;
        end
    end

    assign out_valid         = out_valid_q;
    assign partial_product1  = pp_q[0];
    assign partial_product2  = pp_q[1];
    assign partial_product3  = pp_q[2];
    assign partial_product4  = pp_q[3];
    assign partial_product5  = pp_q[4];
    assign partial_product6  = pp_q[5];
    assign partial_product7  = pp_q[6];
    assign partial_product8  = pp_q[7];
    assign partial_product9  = pp_q[8];
    assign partial_product10 = pp_q[9];
    assign partial_product11 = pp_q[10];
    assign partial_product12 = pp_q[11];
    assign partial_product13 = pp_q[12];

endmodule

// File: tb/tb_booth_pp_gen_24x24.sv
// Self-checking bench for booth_pp_gen_24x24: directed vectors, backpressure,
// throughput and async reset, all scored against an arithmetic Booth model.
module tb_booth_pp_gen_24x24;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] multiplicand;
    logic [23:0] multiplier;
    logic        out_valid;
    logic        out_ready;
    logic [25:0] pp [13];

    typedef struct {
        logic [23:0] a;
        logic [23:0] b;
    } op_t;

    op_t         sb [$];
    int          n_vec = 0;
    int          n_mis = 0;
    int          n_in  = 0;
    int          n_out = 0;
    bit          prev_stall = 0;
    bit          saw_ready_low = 0;
    logic [25:0] prev_pp [13];

    always #5 clk = ~clk;

    booth_pp_gen_24x24 dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .multiplicand      (multiplicand),
        .multiplier        (multiplier),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .partial_product1  (pp[0]),
        .partial_product2  (pp[1]),
        .partial_product3  (pp[2]),
        .partial_product4  (pp[3]),
        .partial_product5  (pp[4]),
        .partial_product6  (pp[5]),
        .partial_product7  (pp[6]),
        .partial_product8  (pp[7]),
        .partial_product9  (pp[8]),
        .partial_product10 (pp[9]),
        .partial_product11 (pp[10]),
        .partial_product12 (pp[11]),
        .partial_product13 (pp[12])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Booth digit from its value definition: b[2k-1] + b[2k] - 2*b[2k+1].
    function automatic logic [25:0] ref_pp(input logic [23:0] a, input logic [23:0] b, input int k);
        logic [63:0] bx;
        logic [63:0] pu;
        int          digit;
        longint      prod;
        bx    = {39'b0, b, 1'b0};
        digit = int'(bx[2*k]) + int'(bx[2*k+1]) - 2 * int'(bx[2*k+2]);
        prod  = longint'(digit) * longint'({40'b0, a});
        pu    = prod;
        return pu[25:0];
    endfunction

    function automatic logic pp_any();
        logic r = 1'b0;
        for (int k = 0; k < 13; k++) r = r | (|pp[k]);
        return r;
    endfunction

    // Monitor: scoreboard push/pop, weighted-sum invariant and stall stability.
    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                for (int k = 0; k < 13; k++) chk($sformatf("stall_pp%0d", k + 1), 64'(pp[k]), 64'(prev_pp[k]));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    op_t         e;
                    logic [63:0] acc;
                    e   = sb.pop_front();
                    acc = '0;
                    for (int k = 0; k < 13; k++) begin
                        chk($sformatf("pp%0d", k + 1), 64'(pp[k]), 64'(ref_pp(e.a, e.b, k)));
                        acc = acc + ({{38{pp[k][25]}}, pp[k]} << (2 * k));
                    end
                    chk("wsum", 64'(acc[51:0]), 64'(e.a) * 64'(e.b));
                    n_out++;
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back('{a: multiplicand, b: multiplier});
                n_in++;
            end
            if (!in_ready) saw_ready_low = 1;
            prev_stall = out_valid && !out_ready;
            for (int k = 0; k < 13; k++) prev_pp[k] = pp[k];
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [23:0] a, input logic [23:0] b);
        bit acc = 0;
        multiplicand = a;
        multiplier   = b;
        in_valid     = 1'b1;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0 && !out_valid) break;
            @(posedge clk);
            #1;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        chk("drain_valid", 64'(out_valid), 64'd0);
    endtask

    // Single op into an empty pipe; out_valid must rise exactly after edge N+2.
    task automatic lat_op(input logic [23:0] a, input logic [23:0] b);
        out_ready    = 1'b1;
        multiplicand = a;
        multiplier   = b;
        in_valid     = 1'b1;
        chk("lat_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("lat_n1", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("lat_n2", 64'(out_valid), 64'd1);
    endtask

    initial begin
        int in0, out0;
        rst          = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        multiplicand = '0;
        multiplier   = '0;
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_pp_zero", 64'(pp_any()), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        lat_op(24'h000001, 24'h000001);
        chk("t1_pp1", 64'(pp[0]), 64'h0000001);
        chk("t1_pp13", 64'(pp[12]), 64'h0);
        lat_op(24'hFFFFFF, 24'hFFFFFF);
        chk("t2_pp1", 64'(pp[0]), 64'h3000001);
        chk("t2_pp7", 64'(pp[6]), 64'h0);
        chk("t2_pp13", 64'(pp[12]), 64'h0FFFFFF);
        lat_op(24'h123456, 24'h000002);
        chk("t3a_pp1", 64'(pp[0]), 64'h3DB9754);
        chk("t3a_pp2", 64'(pp[1]), 64'h0123456);
        lat_op(24'h800000, 24'h000003);
        chk("t3b_pp1", 64'(pp[0]), 64'h3800000);
        chk("t3b_pp2", 64'(pp[1]), 64'h0800000);
        drain();

        // Backpressure: 8 ops with a 5-cycle stall mid-stream.
        in0 = n_in;
        out0 = n_out;
        saw_ready_low = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(24'($urandom), 24'($urandom));
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_in_ready_low", 64'(saw_ready_low), 64'd1);
        chk("bp_in_count", 64'(n_in - in0), 64'd8);
        chk("bp_out_count", 64'(n_out - out0), 64'd8);

        // Random out_ready toggling.
        out0 = n_out;
        fork
            begin
                for (int i = 0; i < 30; i++) send(24'($urandom), 24'($urandom));
                in_valid = 1'b0;
            end
            begin
                repeat (40) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();
        chk("rnd_out_count", 64'(n_out - out0), 64'd30);

        // Throughput: 100 back-to-back ops, 100 outputs within 102 edges.
        in0 = n_in;
        out0 = n_out;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            multiplicand = 24'($urandom);
            multiplier   = 24'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("tp_in_count", 64'(n_in - in0), 64'd100);
        chk("tp_out_count", 64'(n_out - out0), 64'd100);
        @(posedge clk);
        #1;
        drain();

        // Async reset with two ops in flight.
        out_ready = 1'b0;
        send(24'($urandom), 24'($urandom));
        send(24'($urandom), 24'($urandom));
        in_valid = 1'b0;
        chk("r6_full", 64'(out_valid), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("r6_out_valid", 64'(out_valid), 64'd0);
        chk("r6_pp_zero", 64'(pp_any()), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("r6_in_ready", 64'(in_ready), 64'd1);
        lat_op(24'($urandom), 24'($urandom));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
